// File: rtl/game_pkg.sv
// Shared definitions for the bomb/stun interface: tile coordinate width,
// bomb lifecycle states and the system clock rate used for timed durations.
package game_pkg;

  localparam int COORD_W = 6;
  localparam int CLK_HZ  = 50_000_000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    BLAST    = 2'd2,
    COOLDOWN = 2'd3
  } bomb_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter shared by the fuse, blast and cooldown phases.
// Decrement saturates at zero so a stray dec can never wrap the count.
module phase_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/bomb_launcher.sv
// Per-player bomb producer: latches the tile on a place request, runs the
// fuse, emits the explosion pulse and blast window, then enforces cooldown.
//
// state    | meaning
// IDLE     | no bomb in flight; a new placement is accepted if not stunned
// ARMED    | fuse running, bomb sprite shown
// BLAST    | blast window, stun detector samples the bomb tile
// COOLDOWN | waiting before another bomb may be placed
module bomb_launcher
  import game_pkg::*;
#(
  parameter int COORD_W         = game_pkg::COORD_W,
  parameter int FUSE_CYCLES     = 3 * CLK_HZ,
  parameter int BLAST_CYCLES    = 2,
  parameter int COOLDOWN_CYCLES = CLK_HZ
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               placeBomb,
  input  logic [COORD_W-1:0] playerPosX,
  input  logic [COORD_W-1:0] playerPosY,
  input  logic               stunned,
  output logic [COORD_W-1:0] bombPosX,
  output logic [COORD_W-1:0] bombPosY,
  output logic               bombArmed,
  output logic               bombExploded,
  output logic               blastActive,
  output logic               ready
);

  localparam int MAX_CYC = max3(FUSE_CYCLES, BLAST_CYCLES, COOLDOWN_CYCLES);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] FUSE_LOAD  = CNT_W'(FUSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLAST_LOAD = CNT_W'(BLAST_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LOAD  =
    (COOLDOWN_CYCLES > 0) ? CNT_W'(COOLDOWN_CYCLES - 1) : '0;

  bomb_state_t      state, state_n;
  logic             place_d, place_req;
  logic             cnt_load, cnt_dec, cnt_zero, latch_pos;
  logic [CNT_W-1:0] cnt_value;

  phase_counter #(.W(CNT_W)) u_phase_counter (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .value (cnt_value),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

  always_comb begin
    state_n   = state;
    cnt_load  = 1'b0;
    cnt_value = '0;
    cnt_dec   = 1'b0;
    latch_pos = 1'b0;
    case (state)
      IDLE: begin
        if (place_req && !stunned) begin
          state_n   = ARMED;
          latch_pos = 1'b1;
          cnt_load  = 1'b1;
          cnt_value = FUSE_LOAD;
        end
      end
      ARMED: begin
        if (cnt_zero) begin
          state_n   = BLAST;
          cnt_load  = 1'b1;
          cnt_value = BLAST_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      BLAST: begin
        if (cnt_zero) begin
          if (COOLDOWN_CYCLES > 0) begin
            state_n   = COOLDOWN;
            cnt_load  = 1'b1;
            cnt_value = COOL_LOAD;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      COOLDOWN: begin
        if (cnt_zero) state_n = IDLE;
        else          cnt_dec = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      place_d      <= 1'b0;
      place_req    <= 1'b0;
      bombPosX     <= '0;
      bombPosY     <= '0;
      bombArmed    <= 1'b0;
      bombExploded <= 1'b0;
      blastActive  <= 1'b0;
    end else begin
      state        <= state_n;
      place_d      <= placeBomb;
      place_req    <= placeBomb & ~place_d;
      if (latch_pos) begin
        bombPosX <= playerPosX;
        bombPosY <= playerPosY;
      end
      bombArmed    <= (state_n == ARMED);
      blastActive  <= (state_n == BLAST);
      bombExploded <= (state == ARMED) && (state_n == BLAST);
    end
  end

  assign ready = (state == IDLE) && !stunned && !reset;

endmodule

// File: tb/tb_bomb_launcher.sv
// Bench for bomb_launcher: a cooldown build and a zero-cooldown build driven in
// parallel, each compared every cycle against a window-based lifecycle model.
module tb_bomb_launcher;

  localparam int CW = 6;
  localparam int F  = 4;
  localparam int B  = 2;
  localparam int C  = 3;

  logic          clk = 1'b0;
  logic          reset, placeBomb, stunned;
  logic [CW-1:0] playerPosX, playerPosY;

  logic [CW-1:0] bx [2];
  logic [CW-1:0] by [2];
  logic          armed [2], expl [2], blast [2], rdy [2];

  always #5 clk = ~clk;

  bomb_launcher #(.COORD_W(CW), .FUSE_CYCLES(F), .BLAST_CYCLES(B), .COOLDOWN_CYCLES(C)) dut_cd (
    .clk(clk), .reset(reset), .placeBomb(placeBomb),
    .playerPosX(playerPosX), .playerPosY(playerPosY), .stunned(stunned),
    .bombPosX(bx[0]), .bombPosY(by[0]), .bombArmed(armed[0]),
    .bombExploded(expl[0]), .blastActive(blast[0]), .ready(rdy[0])
  );

  bomb_launcher #(.COORD_W(CW), .FUSE_CYCLES(F), .BLAST_CYCLES(B), .COOLDOWN_CYCLES(0)) dut_nc (
    .clk(clk), .reset(reset), .placeBomb(placeBomb),
    .playerPosX(playerPosX), .playerPosY(playerPosY), .stunned(stunned),
    .bombPosX(bx[1]), .bombPosY(by[1]), .bombArmed(armed[1]),
    .bombExploded(expl[1]), .blastActive(blast[1]), .ready(rdy[1])
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model: age = cycles since the bomb was accepted, -1 when no bomb in flight.
  int            age [2];
  int            period [2];
  logic [CW-1:0] mx [2];
  logic [CW-1:0] my [2];
  logic          req_m, prev_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        age[d] = -1;
        mx[d]  = '0;
        my[d]  = '0;
      end else if (age[d] < 0) begin
        if (req_m && !stunned) begin
          age[d] = 0;
          mx[d]  = playerPosX;
          my[d]  = playerPosY;
        end
      end else begin
        age[d]++;
        if (age[d] >= period[d]) age[d] = -1;
      end
    end
    if (reset) begin
      req_m  = 1'b0;
      prev_m = 1'b0;
    end else begin
      req_m  = placeBomb & ~prev_m;
      prev_m = placeBomb;
    end
  endtask

  task automatic check_all();
    string nm;
    for (int d = 0; d < 2; d++) begin
      nm = (d == 0) ? "cd" : "nc";
      chk({nm, ".armed"}, 32'(armed[d]), 32'(age[d] >= 0 && age[d] < F));
      chk({nm, ".exploded"}, 32'(expl[d]), 32'(age[d] == F));
      chk({nm, ".blast"}, 32'(blast[d]), 32'(age[d] >= F && age[d] < F + B));
      chk({nm, ".ready"}, 32'(rdy[d]), 32'(age[d] < 0 && !stunned && !reset));
      chk({nm, ".posx"}, 32'(bx[d]), 32'(mx[d]));
      chk({nm, ".posy"}, 32'(by[d]), 32'(my[d]));
    end
  endtask

  task automatic cyc(input logic pb, input logic st, input logic rs,
                     input logic [CW-1:0] x, input logic [CW-1:0] y);
    placeBomb  = pb;
    stunned    = st;
    reset      = rs;
    playerPosX = x;
    playerPosY = y;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_n(input int n, input logic [CW-1:0] x, input logic [CW-1:0] y);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, x, y);
  endtask

  initial begin
    period[0] = F + B + C;
    period[1] = F + B;
    age[0] = -1; age[1] = -1;
    mx[0] = '0; mx[1] = '0; my[0] = '0; my[1] = '0;
    req_m = 1'b0; prev_m = 1'b0;

    cyc(1'b0, 1'b0, 1'b1, 6'd5, 6'd5);
    cyc(1'b0, 1'b0, 1'b1, 6'd5, 6'd5);
    idle_n(2, 6'd5, 6'd5);

    // basic cycle at (10,20)
    cyc(1'b1, 1'b0, 1'b0, 6'd10, 6'd20);
    idle_n(14, 6'd10, 6'd20);

    // stunned press rejected, then accepted once released
    cyc(1'b1, 1'b1, 1'b0, 6'd1, 6'd2);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 6'd1, 6'd2);
    cyc(1'b1, 1'b0, 1'b0, 6'd3, 6'd4);
    idle_n(12, 6'd3, 6'd4);

    // held level gives one bomb; extra presses during flight are dropped
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0, 6'd7, 6'd8);
    idle_n(4, 6'd7, 6'd8);
    cyc(1'b1, 1'b0, 1'b0, 6'd9, 6'd9);
    for (int i = 0; i < 12; i++) cyc(1'(i % 2), 1'b0, 1'b0, 6'(i), 6'(i + 1));
    idle_n(10, 6'd0, 6'd0);

    // bomb position stays put while the player wanders
    cyc(1'b1, 1'b0, 1'b0, 6'd0, 6'd63);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b0, 6'($urandom), 6'($urandom));

    // reset partway through the fuse, then a normal placement
    cyc(1'b1, 1'b0, 1'b0, 6'd11, 6'd12);
    idle_n(2, 6'd11, 6'd12);
    cyc(1'b0, 1'b0, 1'b1, 6'd11, 6'd12);
    idle_n(8, 6'd11, 6'd12);
    cyc(1'b1, 1'b0, 1'b0, 6'd13, 6'd14);
    idle_n(12, 6'd13, 6'd14);

    // re-press timed so the edge lands right as the zero-cooldown build returns to idle
    cyc(1'b1, 1'b0, 1'b0, 6'd21, 6'd22);
    idle_n(F + B - 1, 6'd21, 6'd22);
    cyc(1'b1, 1'b0, 1'b0, 6'd23, 6'd24);
    idle_n(14, 6'd23, 6'd24);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 99) == 0), 6'($urandom), 6'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bomb_launcher.md
Name: bomb_launcher

Overview:
- Producer side of the bomb/stun interface: one instance per player.
- Accepts a place request, latches the player's current tile as the bomb position, and runs a fuse countdown.
- On expiry it emits the explosion event and holds a blast window, during which the stun detector samples bombPosX/bombPosY.
- A cooldown follows the blast before the next bomb may be placed.

Parameters:
- COORD_W, 6, width of tile X/Y coordinates.
- FUSE_CYCLES, 150000000, fuse length in clk cycles (3 s at 50 MHz); must be >= 1.
- BLAST_CYCLES, 2, cycles blastActive is held; must be >= 1.
- COOLDOWN_CYCLES, 50000000, cycles after blast before re-arm is allowed; 0 means no cooldown.
- CNT_W, $clog2(max(FUSE_CYCLES, BLAST_CYCLES, COOLDOWN_CYCLES)+1), internal counter width (derived).

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- placeBomb  in  1  place request, level from debounced key; acted on at its rising edge only
- playerPosX  in  COORD_W  player tile X
- playerPosY  in  COORD_W  player tile Y
- stunned  in  1  this player's stun enable; blocks placement
- bombPosX  out  COORD_W  latched bomb tile X
- bombPosY  out  COORD_W  latched bomb tile Y
- bombArmed  out  1  high while the fuse runs (drives bomb sprite)
- bombExploded  out  1  single-cycle pulse on the first blast cycle
- blastActive  out  1  high for exactly BLAST_CYCLES cycles
- ready  out  1  high when a placement would be accepted this cycle

Behaviour:
- One clock; reset is synchronous and active-high.
- While reset=1 at a posedge:
  - state goes to IDLE; counter=0; placeBomb edge register=0.
  - bombPosX=bombPosY=0; bombArmed=bombExploded=blastActive=0.
  - ready reads 0 during the reset cycle and 1 afterwards if stunned=0.
- Reset mid-fuse, mid-blast or mid-cooldown aborts with no explosion pulse.
- Edge detect: placeReq = placeBomb & ~placeBomb_d (registered).
- A level held through IDLE does not re-trigger; it must be released and pressed again.
- States:
  - IDLE: if placeReq & ~stunned -> ARMED. In the same edge, latch playerPosX/Y into bombPosX/Y and load counter=FUSE_CYCLES-1. Otherwise stay.
  - ARMED: bombArmed=1. If counter==0 -> BLAST with counter=BLAST_CYCLES-1; else decrement. ARMED lasts exactly FUSE_CYCLES cycles. placeReq is ignored.
  - BLAST: blastActive=1. bombExploded=1 only in the first BLAST cycle (registered flag set on the ARMED->BLAST transition). When counter==0: go to COOLDOWN with counter=COOLDOWN_CYCLES-1 if COOLDOWN_CYCLES>0, else go to IDLE. Otherwise decrement.
  - COOLDOWN: counter==0 -> IDLE, else decrement. placeReq is ignored and not queued.
- All outputs are registered, except ready = (state==IDLE) & ~stunned (combinational).
- Latency: a placeBomb rising edge sampled at posedge t gives bombArmed=1 after posedge t+1 (placeBomb_d adds one cycle).
- Position latch: bombPosX/Y hold their latched value from ARMED through BLAST and COOLDOWN until the next placement. The player moving never alters the bomb position.
- stunned asserted during ARMED/BLAST/COOLDOWN has no effect on the bomb in flight.
- No clamping of coordinates; edge tiles pass through unchanged.
- Counter never underflows: all decrements are guarded by counter!=0.

Decomposition:
- Shared package game_pkg:
  - COORD_W constant.
  - bomb_state_t enum {IDLE, ARMED, BLAST, COOLDOWN}, 2 bits.
  - CLK_HZ=50000000 constant; the stun detector and this block both derive second-based durations from it.
- One sub-module: phase_counter, a loadable down-counter with load/value/dec inputs and a zero flag, shared across the three timed states.

Test Plan (FUSE_CYCLES=4, BLAST_CYCLES=2, COOLDOWN_CYCLES=3, COORD_W=6):
- Basic cycle: pos=(10,20), pulse placeBomb 1 cycle -> bombArmed high 4 cycles; bombPos=(10,20); bombExploded high 1 cycle; blastActive 2 cycles; ready low 3 more cycles, then 1.
- Stunned block: stunned=1, placeBomb rising edge -> state stays IDLE, bombArmed never rises, ready=0; deassert stunned, new edge -> accepted.
- Held/extra presses: placeBomb held high 20 cycles -> exactly one bomb. A second edge during ARMED or COOLDOWN -> ignored, no second bomb after cooldown.
- Position stability: place at (0,63), then change playerPos every cycle -> bombPos stays (0,63) through BLAST.
- Reset mid-fuse: reset on fuse cycle 2 -> all outputs 0 the next cycle, no bombExploded pulse ever; then a new place works normally.
- COOLDOWN_CYCLES=0 build: blast end -> ready=1 on the very next cycle; an immediate re-place is accepted.
